// File: rtl/eth_mac_stats_pkg.sv
// Shared constants for the 10G MAC statistics-vector decoder and counter bank.
package eth_mac_stats_pkg;

    localparam int unsigned RX_VEC_W = 30;
    localparam int unsigned TX_VEC_W = 26;
    localparam int unsigned LEN_W    = 14;
    localparam int unsigned RD_W     = 64;
    localparam int unsigned ADDR_W   = 4;

    // RX statistics vector bit positions
    localparam int unsigned RX_GOOD_BIT  = 0;
    localparam int unsigned RX_BAD_BIT   = 1;
    localparam int unsigned RX_FCS_BIT   = 2;
    localparam int unsigned RX_BCAST_BIT = 3;
    localparam int unsigned RX_MCAST_BIT = 4;
    localparam int unsigned RX_VLAN_BIT  = 7;
    localparam int unsigned RX_LEN_LSB   = 15;

    // TX statistics vector bit positions
    localparam int unsigned TX_GOOD_BIT = 0;
    localparam int unsigned TX_BAD_BIT  = 1;
    localparam int unsigned TX_LEN_LSB  = 5;

    // Frame-counter slots inside the counter bank
    localparam int unsigned NUM_FRM_CNT = 8;
    localparam logic [2:0]  FC_RX_GOOD  = 3'd0;
    localparam logic [2:0]  FC_RX_BAD   = 3'd1;
    localparam logic [2:0]  FC_RX_FCS   = 3'd2;
    localparam logic [2:0]  FC_RX_BCAST = 3'd3;
    localparam logic [2:0]  FC_RX_MCAST = 3'd4;
    localparam logic [2:0]  FC_RX_VLAN  = 3'd5;
    localparam logic [2:0]  FC_TX_GOOD  = 3'd6;
    localparam logic [2:0]  FC_TX_BAD   = 3'd7;

    // Read-port address map
    localparam logic [ADDR_W-1:0] ADDR_RX_GOOD  = 4'd0;
    localparam logic [ADDR_W-1:0] ADDR_RX_BAD   = 4'd1;
    localparam logic [ADDR_W-1:0] ADDR_RX_FCS   = 4'd2;
    localparam logic [ADDR_W-1:0] ADDR_RX_BCAST = 4'd3;
    localparam logic [ADDR_W-1:0] ADDR_RX_MCAST = 4'd4;
    localparam logic [ADDR_W-1:0] ADDR_RX_VLAN  = 4'd5;
    localparam logic [ADDR_W-1:0] ADDR_RX_BYTES = 4'd6;
    localparam logic [ADDR_W-1:0] ADDR_TX_GOOD  = 4'd7;
    localparam logic [ADDR_W-1:0] ADDR_TX_BAD   = 4'd8;
    localparam logic [ADDR_W-1:0] ADDR_TX_BYTES = 4'd9;

    // Decoded RX event; good is already resolved against bad
    typedef struct packed {
        logic             good;
        logic             bad;
        logic             fcs;
        logic             bcast;
        logic             mcast;
        logic             vlan;
        logic [LEN_W-1:0] len;
    } rx_dec_t;

    // Decoded TX event; good is already resolved against bad
    typedef struct packed {
        logic             good;
        logic             bad;
        logic [LEN_W-1:0] len;
    } tx_dec_t;

endpackage

// File: rtl/eth_stat_cnt.sv
// Saturating up-counter; clear loads the same-cycle increment so no event is lost.
module eth_stat_cnt #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned INC_W = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic [INC_W-1:0] i_inc,
    output logic [WIDTH-1:0] o_cnt
);

    localparam int unsigned SUM_W = WIDTH + 1;

    logic [WIDTH-1:0] r_cnt;
    logic [SUM_W-1:0] w_sum;
    logic [WIDTH-1:0] w_next;

    // Clamp the sum at all-ones; on clear only the new increment survives
    always_comb begin
        w_sum  = SUM_W'(r_cnt) + SUM_W'(i_inc);
        w_next = w_sum[WIDTH] ? '1 : w_sum[WIDTH-1:0];
        if (i_clr) begin
            w_next = WIDTH'(i_inc);
        end
    end

    // Counter register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_next;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/eth_mac_stats.sv
// Decodes MAC RX/TX statistics vectors into saturating counters with a snapshot read port.
module eth_mac_stats
    import eth_mac_stats_pkg::*;
#(
    parameter int unsigned CNT_W         = 32,
    parameter int unsigned BYTE_W        = 48,
    parameter bit          CLEAR_ON_SNAP = 1'b1
) (
    input  logic                clk156,
    input  logic                sys_rst_n,
    input  logic [RX_VEC_W-1:0] rx_statistics_vector,
    input  logic                rx_statistics_valid,
    input  logic [TX_VEC_W-1:0] tx_statistics_vector,
    input  logic                tx_statistics_valid,
    input  logic                snap_req,
    output logic                snap_ack,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [RD_W-1:0]     rd_data,
    output logic                rd_valid
);

    rx_dec_t                 w_rx_dec;
    tx_dec_t                 w_tx_dec;
    rx_dec_t                 r_rx;
    tx_dec_t                 r_tx;
    logic                    r_rx_vld;
    logic                    r_tx_vld;
    logic                    w_clr;
    logic [NUM_FRM_CNT-1:0]  w_frm_inc;
    logic [LEN_W-1:0]        w_rx_byte_inc;
    logic [LEN_W-1:0]        w_tx_byte_inc;
    logic [CNT_W-1:0]        w_frm_cnt [NUM_FRM_CNT];
    logic [BYTE_W-1:0]       w_rx_bytes;
    logic [BYTE_W-1:0]       w_tx_bytes;
    logic [CNT_W-1:0]        r_shd_frm [NUM_FRM_CNT];
    logic [BYTE_W-1:0]       r_shd_rx_bytes;
    logic [BYTE_W-1:0]       r_shd_tx_bytes;
    logic [RD_W-1:0]         w_rd_mux;
    logic [RD_W-1:0]         r_rd_data;
    logic                    r_rd_valid;
    logic                    r_snap_ack;
    logic                    w_unused_vec_bits;

    // Reserved vector bits carry no counted information
    assign w_unused_vec_bits = ^{rx_statistics_vector[29], rx_statistics_vector[14:8],
                                 rx_statistics_vector[6:5], tx_statistics_vector[25:19],
                                 tx_statistics_vector[4:2]};

    // Field decode; a vector flagged both good and bad counts only as bad
    always_comb begin
        w_rx_dec       = '0;
        w_rx_dec.bad   = rx_statistics_vector[RX_BAD_BIT];
        w_rx_dec.good  = rx_statistics_vector[RX_GOOD_BIT] & ~rx_statistics_vector[RX_BAD_BIT];
        w_rx_dec.fcs   = rx_statistics_vector[RX_FCS_BIT];
        w_rx_dec.bcast = rx_statistics_vector[RX_BCAST_BIT];
        w_rx_dec.mcast = rx_statistics_vector[RX_MCAST_BIT];
        w_rx_dec.vlan  = rx_statistics_vector[RX_VLAN_BIT];
        w_rx_dec.len   = rx_statistics_vector[RX_LEN_LSB +: LEN_W];
        w_tx_dec       = '0;
        w_tx_dec.bad   = tx_statistics_vector[TX_BAD_BIT];
        w_tx_dec.good  = tx_statistics_vector[TX_GOOD_BIT] & ~tx_statistics_vector[TX_BAD_BIT];
        w_tx_dec.len   = tx_statistics_vector[TX_LEN_LSB +: LEN_W];
    end

    // Stage 1: register qualifiers and decoded fields
    always_ff @(posedge clk156) begin
        if (!sys_rst_n) begin
            r_rx_vld <= 1'b0;
            r_tx_vld <= 1'b0;
            r_rx     <= '0;
            r_tx     <= '0;
        end else begin
            r_rx_vld <= rx_statistics_valid;
            r_tx_vld <= tx_statistics_valid;
            r_rx     <= w_rx_dec;
            r_tx     <= w_tx_dec;
        end
    end

    // Stage 2 increments; bytes accumulate for good frames only
    always_comb begin
        w_frm_inc              = '0;
        w_frm_inc[FC_RX_GOOD]  = r_rx_vld & r_rx.good;
        w_frm_inc[FC_RX_BAD]   = r_rx_vld & r_rx.bad;
        w_frm_inc[FC_RX_FCS]   = r_rx_vld & r_rx.fcs;
        w_frm_inc[FC_RX_BCAST] = r_rx_vld & r_rx.bcast;
        w_frm_inc[FC_RX_MCAST] = r_rx_vld & r_rx.mcast;
        w_frm_inc[FC_RX_VLAN]  = r_rx_vld & r_rx.vlan;
        w_frm_inc[FC_TX_GOOD]  = r_tx_vld & r_tx.good;
        w_frm_inc[FC_TX_BAD]   = r_tx_vld & r_tx.bad;
        w_rx_byte_inc          = (r_rx_vld && r_rx.good) ? r_rx.len : '0;
        w_tx_byte_inc          = (r_tx_vld && r_tx.good) ? r_tx.len : '0;
    end

    assign w_clr = snap_req && CLEAR_ON_SNAP;

    // Live frame counters
    for (genvar g = 0; g < NUM_FRM_CNT; g++) begin : g_frm
        eth_stat_cnt #(
            .WIDTH (CNT_W),
            .INC_W (1)
        ) u_cnt (
            .i_clk   (clk156),
            .i_rst_n (sys_rst_n),
            .i_clr   (w_clr),
            .i_inc   (w_frm_inc[g]),
            .o_cnt   (w_frm_cnt[g])
        );
    end

    // Live RX byte counter
    eth_stat_cnt #(
        .WIDTH (BYTE_W),
        .INC_W (LEN_W)
    ) u_rx_bytes (
        .i_clk   (clk156),
        .i_rst_n (sys_rst_n),
        .i_clr   (w_clr),
        .i_inc   (w_rx_byte_inc),
        .o_cnt   (w_rx_bytes)
    );

    // Live TX byte counter
    eth_stat_cnt #(
        .WIDTH (BYTE_W),
        .INC_W (LEN_W)
    ) u_tx_bytes (
        .i_clk   (clk156),
        .i_rst_n (sys_rst_n),
        .i_clr   (w_clr),
        .i_inc   (w_tx_byte_inc),
        .o_cnt   (w_tx_bytes)
    );

    // Shadow bank copies live values as they stood before this edge's update
    always_ff @(posedge clk156) begin
        if (!sys_rst_n) begin
            r_shd_frm      <= '{default: '0};
            r_shd_rx_bytes <= '0;
            r_shd_tx_bytes <= '0;
            r_snap_ack     <= 1'b0;
        end else begin
            r_snap_ack <= snap_req;
            if (snap_req) begin
                r_shd_frm      <= w_frm_cnt;
                r_shd_rx_bytes <= w_rx_bytes;
                r_shd_tx_bytes <= w_tx_bytes;
            end
        end
    end

    // Address decode over the shadow bank, zero-extended
    always_comb begin
        w_rd_mux = '0;
        case (rd_addr)
            ADDR_RX_GOOD:  w_rd_mux = RD_W'(r_shd_frm[FC_RX_GOOD]);
            ADDR_RX_BAD:   w_rd_mux = RD_W'(r_shd_frm[FC_RX_BAD]);
            ADDR_RX_FCS:   w_rd_mux = RD_W'(r_shd_frm[FC_RX_FCS]);
            ADDR_RX_BCAST: w_rd_mux = RD_W'(r_shd_frm[FC_RX_BCAST]);
            ADDR_RX_MCAST: w_rd_mux = RD_W'(r_shd_frm[FC_RX_MCAST]);
            ADDR_RX_VLAN:  w_rd_mux = RD_W'(r_shd_frm[FC_RX_VLAN]);
            ADDR_RX_BYTES: w_rd_mux = RD_W'(r_shd_rx_bytes);
            ADDR_TX_GOOD:  w_rd_mux = RD_W'(r_shd_frm[FC_TX_GOOD]);
            ADDR_TX_BAD:   w_rd_mux = RD_W'(r_shd_frm[FC_TX_BAD]);
            ADDR_TX_BYTES: w_rd_mux = RD_W'(r_shd_tx_bytes);
            default:       w_rd_mux = '0;
        endcase
    end

    // Registered read port; data holds between reads
    always_ff @(posedge clk156) begin
        if (!sys_rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_data <= w_rd_mux;
            end
        end
    end

    assign snap_ack = r_snap_ack;
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;

endmodule

// File: tb/tb_eth_mac_stats.sv
// Directed bench: two DUT configurations against an event-level counter model.
module tb_eth_mac_stats;

    logic        clk156 = 1'b0;
    logic        sys_rst_n;
    logic [29:0] rx_vec;
    logic        rx_vld;
    logic [25:0] tx_vec;
    logic        tx_vld;
    logic        snap_req;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic        ack0, ack1, rv0, rv1;
    logic [63:0] rd0, rd1;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk156 = ~clk156;

    // Full-width counters, clear on snapshot
    eth_mac_stats #(.CNT_W(32), .BYTE_W(48), .CLEAR_ON_SNAP(1'b1)) u_dut0 (
        .clk156(clk156), .sys_rst_n(sys_rst_n),
        .rx_statistics_vector(rx_vec), .rx_statistics_valid(rx_vld),
        .tx_statistics_vector(tx_vec), .tx_statistics_valid(tx_vld),
        .snap_req(snap_req), .snap_ack(ack0),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd0), .rd_valid(rv0)
    );

    // Narrow free-running counters so saturation is reachable quickly
    eth_mac_stats #(.CNT_W(8), .BYTE_W(16), .CLEAR_ON_SNAP(1'b0)) u_dut1 (
        .clk156(clk156), .sys_rst_n(sys_rst_n),
        .rx_statistics_vector(rx_vec), .rx_statistics_valid(rx_vld),
        .tx_statistics_vector(tx_vec), .tx_statistics_valid(tx_vld),
        .snap_req(snap_req), .snap_ack(ack1),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd1), .rd_valid(rv1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Index = read address. A vector sampled at one edge lands in the live
    // counts at the next edge; a snapshot sees live counts before that landing.
    longint unsigned m_live [2][10];
    longint unsigned m_shd  [2][10];
    longint unsigned m_pend [10];
    longint unsigned m_cmax [2] = '{64'hFFFF_FFFF, 64'hFF};
    longint unsigned m_bmax [2] = '{64'hFFFF_FFFF_FFFF, 64'hFFFF};
    bit              m_clear[2] = '{1'b1, 1'b0};
    logic            exp_rv [2];
    logic            exp_ack[2];
    logic [63:0]     exp_rd [2];
    bit              chk_en = 1'b0;

    always @(posedge clk156) begin
        if (!sys_rst_n) begin
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < 10; k++) begin
                    m_live[d][k] = 0;
                    m_shd[d][k]  = 0;
                end
                exp_rv[d]  = 1'b0;
                exp_ack[d] = 1'b0;
                exp_rd[d]  = '0;
            end
            for (int k = 0; k < 10; k++) m_pend[k] = 0;
            chk_en = 1'b1;
        end else begin
            for (int d = 0; d < 2; d++) begin
                longint unsigned lim, sum;
                exp_rv[d]  = rd_en;
                exp_ack[d] = snap_req;
                if (rd_en) exp_rd[d] = (rd_addr < 4'd10) ? 64'(m_shd[d][rd_addr]) : 64'd0;
                for (int k = 0; k < 10; k++) begin
                    if (snap_req) begin
                        m_shd[d][k] = m_live[d][k];
                        if (m_clear[d]) m_live[d][k] = 0;
                    end
                    lim = (k == 6 || k == 9) ? m_bmax[d] : m_cmax[d];
                    sum = m_live[d][k] + m_pend[k];
                    m_live[d][k] = (sum > lim) ? lim : sum;
                end
            end
            begin
                bit rg, tg;
                rg = rx_vld && rx_vec[0] && !rx_vec[1];
                tg = tx_vld && tx_vec[0] && !tx_vec[1];
                m_pend[0] = longint'(rg);
                m_pend[1] = longint'(rx_vld && rx_vec[1]);
                m_pend[2] = longint'(rx_vld && rx_vec[2]);
                m_pend[3] = longint'(rx_vld && rx_vec[3]);
                m_pend[4] = longint'(rx_vld && rx_vec[4]);
                m_pend[5] = longint'(rx_vld && rx_vec[7]);
                m_pend[6] = rg ? longint'(rx_vec[28:15]) : 0;
                m_pend[7] = longint'(tg);
                m_pend[8] = longint'(tx_vld && tx_vec[1]);
                m_pend[9] = tg ? longint'(tx_vec[18:5]) : 0;
            end
        end
    end

    // Compare DUT outputs against the model every cycle, away from the clock edge
    always @(negedge clk156) begin
        if (chk_en) begin
            chk("dut0_rd_valid", 64'(rv0), 64'(exp_rv[0]));
            chk("dut1_rd_valid", 64'(rv1), 64'(exp_rv[1]));
            chk("dut0_snap_ack", 64'(ack0), 64'(exp_ack[0]));
            chk("dut1_snap_ack", 64'(ack1), 64'(exp_ack[1]));
            if (exp_rv[0]) chk("dut0_rd_data", rd0, exp_rd[0]);
            if (exp_rv[1]) chk("dut1_rd_data", rd1, exp_rd[1]);
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [29:0] mkrx(input bit good, input bit bad, input bit fcs,
                                         input bit bc, input bit mc, input bit vlan,
                                         input logic [13:0] len);
        logic [29:0] v;
        v       = '0;
        v[0]    = good;
        v[1]    = bad;
        v[2]    = fcs;
        v[3]    = bc;
        v[4]    = mc;
        v[7]    = vlan;
        v[28:15] = len;
        return v;
    endfunction

    function automatic logic [25:0] mktx(input bit good, input bit bad, input logic [13:0] len);
        logic [25:0] v;
        v       = '0;
        v[0]    = good;
        v[1]    = bad;
        v[18:5] = len;
        return v;
    endfunction

    task automatic send_rx(input logic [29:0] v);
        rx_vec = v;
        rx_vld = 1'b1;
        @(negedge clk156);
        rx_vld = 1'b0;
    endtask

    task automatic do_snap();
        repeat (2) @(negedge clk156);
        snap_req = 1'b1;
        @(negedge clk156);
        snap_req = 1'b0;
        @(negedge clk156);
    endtask

    task automatic rd_chk(input int d, input logic [3:0] a, input logic [63:0] exp, input string name);
        rd_en   = 1'b1;
        rd_addr = a;
        @(negedge clk156);
        rd_en = 1'b0;
        chk(name, (d == 0) ? rd0 : rd1, exp);
    endtask

    initial begin
        sys_rst_n = 1'b0;
        rx_vec = '0; rx_vld = 1'b0;
        tx_vec = '0; tx_vld = 1'b0;
        snap_req = 1'b0; rd_en = 1'b0; rd_addr = '0;
        repeat (3) @(negedge clk156);
        chk("reset_rd_data", rd0, 64'd0);
        chk("reset_rd_valid", 64'(rv0), 64'd0);
        chk("reset_snap_ack", 64'(ack0), 64'd0);
        sys_rst_n = 1'b1;

        // Empty bank: every address reads zero, back-to-back
        do_snap();
        for (int a = 0; a < 16; a++) rd_chk(0, 4'(a), 64'd0, $sformatf("empty_addr%0d", a));

        // Five good 64-byte frames, two broadcast
        for (int i = 0; i < 5; i++) send_rx(mkrx(1, 0, 0, (i < 2), 0, 0, 14'd64));
        do_snap();
        rd_chk(0, 4'd0, 64'd5,   "rx_good_5");
        rd_chk(0, 4'd6, 64'd320, "rx_bytes_320");
        rd_chk(0, 4'd3, 64'd2,   "rx_bcast_2");
        rd_chk(0, 4'd1, 64'd0,   "rx_bad_0");

        // Good+bad with FCS counts only as bad; a neither-frame still counts classes
        send_rx(mkrx(1, 1, 1, 0, 0, 0, 14'd100));
        send_rx(mkrx(0, 0, 0, 0, 1, 1, 14'd50));
        do_snap();
        rd_chk(0, 4'd1, 64'd1, "gb_rx_bad");
        rd_chk(0, 4'd2, 64'd1, "gb_rx_fcs");
        rd_chk(0, 4'd0, 64'd0, "gb_rx_good");
        rd_chk(0, 4'd6, 64'd0, "gb_rx_bytes");
        rd_chk(0, 4'd4, 64'd1, "cls_rx_mcast");
        rd_chk(0, 4'd5, 64'd1, "cls_rx_vlan");

        // Simultaneous RX and TX good frames
        rx_vec = mkrx(1, 0, 0, 0, 0, 0, 14'd60);
        tx_vec = mktx(1, 0, 14'd1518);
        rx_vld = 1'b1; tx_vld = 1'b1;
        @(negedge clk156);
        rx_vld = 1'b0; tx_vld = 1'b0;
        do_snap();
        rd_chk(0, 4'd6, 64'd60,   "sim_rx_bytes");
        rd_chk(0, 4'd9, 64'd1518, "sim_tx_bytes");
        rd_chk(0, 4'd7, 64'd1,    "sim_tx_good");
        rd_chk(0, 4'd0, 64'd1,    "sim_rx_good");

        // Snapshot coincident with the stage-2 landing of a frame
        send_rx(mkrx(1, 0, 0, 0, 0, 0, 14'd200));
        snap_req = 1'b1;
        @(negedge clk156);
        snap_req = 1'b0;
        rd_chk(0, 4'd0, 64'd0, "coinc_snap1_rx_good");
        rd_chk(0, 4'd6, 64'd0, "coinc_snap1_rx_bytes");
        snap_req = 1'b1; rd_en = 1'b1; rd_addr = 4'd0;
        @(negedge clk156);
        snap_req = 1'b0; rd_en = 1'b0;
        chk("read_during_snap", rd0, 64'd0);
        rd_chk(0, 4'd0, 64'd1,   "coinc_snap2_rx_good");
        rd_chk(0, 4'd6, 64'd200, "coinc_snap2_rx_bytes");
        rd_chk(1, 4'd0, 64'd7,   "noclear_rx_good");
        rd_chk(1, 4'd6, 64'd580, "noclear_rx_bytes");

        // Snapshot requested every cycle
        snap_req = 1'b1;
        repeat (3) @(negedge clk156);
        snap_req = 1'b0;
        @(negedge clk156);

        // Reset while a frame sits in stage 1
        send_rx(mkrx(1, 0, 0, 0, 0, 0, 14'd77));
        sys_rst_n = 1'b0;
        repeat (2) @(negedge clk156);
        sys_rst_n = 1'b1;
        rd_chk(1, 4'd0, 64'd0, "rst_shadow_cleared");
        do_snap();
        rd_chk(0, 4'd0, 64'd0, "rst_inflight_dut0");
        rd_chk(1, 4'd0, 64'd0, "rst_inflight_dut1");

        // Drive the narrow frame counter to max-1, then past it
        rx_vec = mkrx(1, 0, 0, 0, 0, 0, 14'd0);
        rx_vld = 1'b1;
        repeat (254) @(negedge clk156);
        rx_vld = 1'b0;
        do_snap();
        rd_chk(1, 4'd0, 64'd254, "sat_pre_rx_good");
        rd_chk(1, 4'd6, 64'd0,   "zero_len_bytes");
        rx_vec = mkrx(1, 0, 0, 0, 0, 0, 14'h3FFF);
        rx_vld = 1'b1;
        repeat (3) @(negedge clk156);
        rx_vld = 1'b0;
        do_snap();
        rd_chk(1, 4'd0, 64'd255,   "sat_rx_good");
        rd_chk(1, 4'd6, 64'd49149, "bytes_pre_clamp");
        rx_vld = 1'b1;
        repeat (2) @(negedge clk156);
        rx_vld = 1'b0;
        do_snap();
        rd_chk(1, 4'd0, 64'd255,   "sat_rx_good_hold");
        rd_chk(1, 4'd6, 64'd65535, "sat_rx_bytes_clamp");
        rd_chk(0, 4'd0, 64'd2,     "wide_rx_good");
        rd_chk(0, 4'd6, 64'd32766, "wide_rx_bytes");

        repeat (3) @(negedge clk156);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
